// File: rtl/clock_gen_param.sv
// rtl/clock_gen_param.sv - reference-clock divider producing fast, 2 Hz, 1 Hz and blink outputs
// Two independent dividers: a half-period counter for CLK_FAST and a quarter-second counter with phase PH.
module clock_gen_param #(
  parameter int REF_HZ   = 100000000,
  parameter int FAST_HZ  = 500,
  parameter int BLINK_ON = 2
) (
  input  logic CLK_REF,
  input  logic CLK_RES,
  input  logic HOLD,
  input  logic BLINK_EN,
  output logic CLK_FAST,
  output logic CLK_2HZ,
  output logic CLK_1HZ,
  output logic CLK_BLINK,
  output logic TICK_FAST,
  output logic TICK_2HZ,
  output logic TICK_1HZ
);

  localparam int HALF_FAST = REF_HZ / (2 * FAST_HZ);
  localparam int QUARTER   = REF_HZ / 4;
  localparam int FW        = (HALF_FAST > 1) ? $clog2(HALF_FAST) : 1;
  localparam int QW        = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [FW-1:0] FAST_LAST    = FW'(HALF_FAST - 1);
  localparam logic [QW-1:0] QUARTER_LAST = QW'(QUARTER - 1);
  localparam logic [2:0]    BLINK_LIM    = 3'(BLINK_ON);

  if ((REF_HZ % 4) != 0 || (REF_HZ % (2 * FAST_HZ)) != 0 || HALF_FAST < 1 ||
      BLINK_ON < 0 || BLINK_ON > 4) begin : g_bad_params
    $fatal(1, "clock_gen_param: illegal parameter set");
  end

  logic [FW-1:0] fast_cnt_q, fast_cnt_d;
  logic [QW-1:0] qtr_cnt_q, qtr_cnt_d;
  logic [1:0]    ph_q, ph_d;
  logic clk_fast_q, clk_fast_d;
  logic clk_2hz_q, clk_2hz_d;
  logic clk_1hz_q, clk_1hz_d;
  logic blink_q, blink_d;
  logic tick_fast_q, tick_fast_d;
  logic tick_2hz_q, tick_2hz_d;
  logic tick_1hz_q, tick_1hz_d;

  always_comb begin
    fast_cnt_d  = fast_cnt_q;
    qtr_cnt_d   = qtr_cnt_q;
    ph_d        = ph_q;
    clk_fast_d  = clk_fast_q;
    clk_2hz_d   = clk_2hz_q;
    clk_1hz_d   = clk_1hz_q;
    blink_d     = blink_q;
    tick_fast_d = 1'b0;
    tick_2hz_d  = 1'b0;
    tick_1hz_d  = 1'b0;
    if (!HOLD) begin
      if (fast_cnt_q == FAST_LAST) begin
        fast_cnt_d  = '0;
        clk_fast_d  = ~clk_fast_q;
        tick_fast_d = ~clk_fast_q;
      end else begin
        fast_cnt_d = fast_cnt_q + 1'b1;
      end
      if (qtr_cnt_q == QUARTER_LAST) begin
        qtr_cnt_d  = '0;
        ph_d       = ph_q + 2'd1;
        clk_2hz_d  = ~clk_2hz_q;
        tick_2hz_d = ~clk_2hz_q;
        // 1 Hz flips every second quarter: on the 1->2 and 3->0 phase steps
        if (ph_q[0]) begin
          clk_1hz_d  = ~clk_1hz_q;
          tick_1hz_d = ~clk_1hz_q;
        end
      end else begin
        qtr_cnt_d = qtr_cnt_q + 1'b1;
      end
      blink_d = BLINK_EN && ({1'b0, ph_d} < BLINK_LIM);
    end
  end

  always_ff @(posedge CLK_REF) begin
    if (CLK_RES) begin
      fast_cnt_q  <= '0;
      qtr_cnt_q   <= '0;
      ph_q        <= '0;
      clk_fast_q  <= 1'b0;
      clk_2hz_q   <= 1'b0;
      clk_1hz_q   <= 1'b0;
      blink_q     <= 1'b0;
      tick_fast_q <= 1'b0;
      tick_2hz_q  <= 1'b0;
      tick_1hz_q  <= 1'b0;
    end else begin
      fast_cnt_q  <= fast_cnt_d;
      qtr_cnt_q   <= qtr_cnt_d;
      ph_q        <= ph_d;
      clk_fast_q  <= clk_fast_d;
      clk_2hz_q   <= clk_2hz_d;
      clk_1hz_q   <= clk_1hz_d;
      blink_q     <= blink_d;
      tick_fast_q <= tick_fast_d;
      tick_2hz_q  <= tick_2hz_d;
      tick_1hz_q  <= tick_1hz_d;
    end
  end

  assign CLK_FAST  = clk_fast_q;
  assign CLK_2HZ   = clk_2hz_q;
  assign CLK_1HZ   = clk_1hz_q;
  assign CLK_BLINK = blink_q;
  assign TICK_FAST = tick_fast_q;
  assign TICK_2HZ  = tick_2hz_q;
  assign TICK_1HZ  = tick_1hz_q;

endmodule

// File: tb/tb_clock_gen_param.sv
// tb/tb_clock_gen_param.sv - scoreboard bench for clock_gen_param
// Expected outputs derive from the count of non-held edges since reset, using plain division.
module tb_clock_gen_param;

  localparam int REF_HZ   = 40;
  localparam int FAST_HZ  = 5;
  localparam int BLINK_ON = 1;
  localparam int HF = REF_HZ / (2 * FAST_HZ);
  localparam int QT = REF_HZ / 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic hold = 1'b0;
  logic ben = 1'b0;
  logic clk_fast, clk_2hz, clk_1hz, clk_blink, tick_fast, tick_2hz, tick_1hz;

  clock_gen_param #(.REF_HZ(REF_HZ), .FAST_HZ(FAST_HZ), .BLINK_ON(BLINK_ON)) dut (
    .CLK_REF  (clk),
    .CLK_RES  (res),
    .HOLD     (hold),
    .BLINK_EN (ben),
    .CLK_FAST (clk_fast),
    .CLK_2HZ  (clk_2hz),
    .CLK_1HZ  (clk_1hz),
    .CLK_BLINK(clk_blink),
    .TICK_FAST(tick_fast),
    .TICK_2HZ (tick_2hz),
    .TICK_1HZ (tick_1hz)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q[$];
  int         tag_q[$];
  int total = 0;
  int bad = 0;
  int n = 0;
  int step_no = 0;
  logic m_blink = 1'b0;

  // n counts non-held edges since reset; every output is a function of n plus the last sampled blink
  task automatic step(input logic r, input logic h, input logic b);
    logic tf, t2, t1;
    logic [6:0] e;
    @(negedge clk);
    res = r; hold = h; ben = b;
    tf = 1'b0; t2 = 1'b0; t1 = 1'b0;
    if (r) begin
      n = 0;
      m_blink = 1'b0;
    end else if (!h) begin
      n++;
      tf = (n % (2 * HF)) == HF;
      t2 = (n % (2 * QT)) == QT;
      t1 = (n % (4 * QT)) == 2 * QT;
      m_blink = b && (((n / QT) % 4) < BLINK_ON);
    end
    e = {((n / HF) % 2) != 0, ((n / QT) % 2) != 0, ((n / QT) % 4) >= 2, m_blink, tf, t2, t1};
    step_no++;
    exp_q.push_back(e);
    tag_q.push_back(step_no);
  endtask

  initial begin : monitor
    logic [6:0] e, got;
    int t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {clk_fast, clk_2hz, clk_1hz, clk_blink, tick_fast, tick_2hz, tick_1hz};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL outs step=%0d got fast/2hz/1hz/blink/tf/t2/t1=%b want=%b", t, got, e);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    logic b;
    // reset with arbitrary HOLD/BLINK_EN
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 1'(i / 2));
    // free run with blink enabled, drop BLINK_EN from edge 45
    for (int k = 1; k <= 61; k++) step(1'b0, 1'b0, k < 45);
    // hold for edges 15..21
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) step(1'b0, (k >= 15 && k <= 21), 1'b1);
    // reset while held at edge 33, then restart from zero
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 32; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 61; k++) step(1'b0, 1'b0, 1'b1);
    // randomized hold, enable and occasional reset
    b = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) b = ~b;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, b);
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
